alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
- Front-end stage directly upstream of the lab's N-bit ALU. On the FPGA board it collects operand A, operand B and the 4-bit opcode from switches, one push-button step at a time.
- Drives the ALU's a/b/control inputs from internal registers, which gives the combinational ALU stable inputs.
- Captures the ALU result and V/C/N/Z flags into display registers, with an error indication for illegal operations.

Parameters:
- N, 4, operand/result width; must match the ALU's N.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sw  in  N  data switches (operand entry)
- op_sw  in  4  opcode switches
- btn_next  in  1  raw asynchronous step button, active-high
- alu_a  out  N  operand A to ALU (registered)
- alu_b  out  N  operand B to ALU (registered)
- alu_control  out  4  opcode to ALU (registered)
- alu_result  in  N  ALU result
- alu_v, alu_c, alu_n, alu_z  in  1 each  ALU flags
- result_q  out  N  captured result
- flags_q  out  4  captured flags {v,c,n,z}
- phase  out  3  current state encoding, for LED display
- valid  out  1  result_q/flags_q hold a fresh result
- err  out  1  captured operation was illegal

Behaviour:
- Interface decision: one clock, clk; reset rst is synchronous and active-high.
- Reset: every register and output returns to 0; state goes to LOAD_A. A reset in any state, including EXEC, wins over a step on the same edge.
- Button path:
  - btn_next passes through a 2-flop synchronizer, then a rising-edge detector.
  - The detector produces a one-cycle internal pulse, step.
  - step rises on the 3rd rising clk edge after btn_next is first sampled high.
  - Holding the button produces exactly one step. There is no debounce in this block; the board wrapper supplies a clean level.
- State encoding (phase): LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4.
- LOAD_A: on step, a_reg<=sw, go to LOAD_B, and clear valid and err.
- LOAD_B: on step, b_reg<=sw, go to LOAD_OP.
- LOAD_OP: on step, op_reg<=op_sw, go to EXEC.
- EXEC: lasts exactly one cycle and ignores step. On the exiting edge it captures result/flags and goes to SHOW.
- SHOW: holds the captured values. On step, go to LOAD_A.
- ALU drive: alu_a=a_reg, alu_b=b_reg, alu_control=op_reg, all continuously. Registers change only at their own load states.
- Capture rules at the end of EXEC:
  - Legal op: result_q<=alu_result, flags_q<={alu_v,alu_c,alu_n,alu_z}, err<=0, valid<=1.
  - Illegal if op_reg>9, or if op_reg is 7 (mod) or 9 (div) with b_reg==0. Then result_q<=0, flags_q<=0, err<=1, valid<=1.
- Opcode map: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 lsr, 6 lsl, 7 mod, 8 pass-A, 9 div.
- In SHOW, result_q/flags_q/valid/err stay stable until the next step.
- A step in SHOW clears valid and err on that edge. result_q and flags_q keep their old values until the next capture.
- sw/op_sw changes outside the load edges have no effect.

Decomposition:
- Package alu_seq_pkg holds:
  - state_t enum {LOAD_A, LOAD_B, LOAD_OP, EXEC, SHOW} with the encoding above;
  - opcode constants OP_ADD..OP_DIV (0..9) and OP_MAX=9;
  - flag bit indices FLAG_V=3, FLAG_C=2, FLAG_N=1, FLAG_Z=0.
- Sub-module btn_step_sync contains the 2-flop synchronizer and rising-edge pulse generator (clk, rst, btn_in, step).
- The FSM and capture registers live in the top module.

Test Plan (N=4, ALU instantiated in the bench):
- Add with carry:
  - Stimulus: press with sw=4'h9, press with sw=4'h8, press with op_sw=0.
  - Response: phase steps 0→1→2→3→4; EXEC is one cycle; result_q=4'h1, flags_q=4'b1100 (V=1, C=1), valid=1, err=0.
- Subtract to zero:
  - Stimulus: A=5, B=5, op=1.
  - Response: result_q=0, Z=1, C=1, valid=1.
- Divide by zero:
  - Stimulus: A=7, B=0, op=9.
  - Response: err=1, valid=1, result_q=0, flags_q=0. The same A=7, B=0 with op=7 (mod) also gives err=1.
- Illegal opcode:
  - Stimulus: op=4'hC.
  - Response: err=1, result_q=0. Then a step in SHOW gives phase=0, valid=0, err=0, while result_q holds its value.
- Button hold and pulse width:
  - Stimulus: hold btn_next high for 20 cycles in LOAD_A.
  - Response: exactly one transition to LOAD_B, occurring 3 edges after the press; a_reg matches sw at that edge.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle while phase=3 (EXEC) with a step pending.
  - Response: next cycle phase=0, all outputs 0, no capture occurs.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_LSR  = 4'd5;
    localparam logic [3:0] OP_LSL  = 4'd6;
    localparam logic [3:0] OP_MOD  = 4'd7;
    localparam logic [3:0] OP_PASS = 4'd8;
    localparam logic [3:0] OP_DIV  = 4'd9;
    localparam logic [3:0] OP_MAX  = OP_DIV;

    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    // An operation is illegal when the opcode is unassigned, or when it
    // divides (div or mod) by a zero operand B.
    function automatic logic is_illegal(input logic [3:0] op, input logic b_is_zero);
        return (op > OP_MAX) || (((op == OP_MOD) || (op == OP_DIV)) && b_is_zero);
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_btn_step_sync.sv
// Two-flop synchronizer for the raw step button followed by a rising-edge
// detector that emits a single-cycle step pulse per press.
module btn_step_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic step
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    // Synchronize the button, then register a pulse on the first high sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
            step    <= 1'b0;
        end else begin
            sync1   <= btn_in;
            sync2   <= sync1;
            sync2_d <= sync2;
            step    <= sync2 & ~sync2_d;
        end
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects operands and opcode one button step at a time, drives a
// combinational ALU from stable registers and captures its result and flags.
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw,
    input  logic [3:0]   op_sw,
    input  logic         btn_next,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_control,
    input  logic [N-1:0] alu_result,
    input  logic         alu_v,
    input  logic         alu_c,
    input  logic         alu_n,
    input  logic         alu_z,
    output logic [N-1:0] result_q,
    output logic [3:0]   flags_q,
    output logic [2:0]   phase,
    output logic         valid,
    output logic         err
);

    state_t       state;
    state_t       next_state;
    logic         step;
    logic [N-1:0] a_reg;
    logic [N-1:0] b_reg;
    logic [3:0]   op_reg;
    logic         illegal;

    btn_step_sync u_step (
        .clk    (clk),
        .rst    (rst),
        .btn_in (btn_next),
        .step   (step)
    );

    assign alu_a       = a_reg;
    assign alu_b       = b_reg;
    assign alu_control = op_reg;
    assign phase       = state;
    assign illegal     = is_illegal(op_reg, b_reg == '0);

    // State register; reset takes priority over any pending step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD_A;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: load states advance on step, EXEC always lasts one cycle.
    always_comb begin
        next_state = state;
        case (state)
            LOAD_A:  if (step) next_state = LOAD_B;
            LOAD_B:  if (step) next_state = LOAD_OP;
            LOAD_OP: if (step) next_state = EXEC;
            EXEC:    next_state = SHOW;
            SHOW:    if (step) next_state = LOAD_A;
            default: next_state = LOAD_A;
        endcase
    end

    // Operand, opcode and capture registers, each written only in its own state.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= '0;
            result_q <= '0;
            flags_q  <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (step) begin
                        a_reg <= sw;
                        valid <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                LOAD_B: begin
                    if (step) b_reg <= sw;
                end
                LOAD_OP: begin
                    if (step) op_reg <= op_sw;
                end
                EXEC: begin
                    valid <= 1'b1;
                    if (illegal) begin
                        result_q <= '0;
                        flags_q  <= '0;
                        err      <= 1'b1;
                    end else begin
                        result_q        <= alu_result;
                        flags_q[FLAG_V] <= alu_v;
                        flags_q[FLAG_C] <= alu_c;
                        flags_q[FLAG_N] <= alu_n;
                        flags_q[FLAG_Z] <= alu_z;
                        err             <= 1'b0;
                    end
                end
                SHOW: begin
                    if (step) begin
                        valid <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench: a behavioural ALU drives the sequencer, and a
// transaction-level model predicts phase, operands and captured results.
module tb_alu_operand_sequencer;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] sw;
    logic [3:0]   op_sw;
    logic         btn_next;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_control;
    logic [N-1:0] alu_result;
    logic         alu_v;
    logic         alu_c;
    logic         alu_n;
    logic         alu_z;
    logic [N-1:0] result_q;
    logic [3:0]   flags_q;
    logic [2:0]   phase;
    logic         valid;
    logic         err;

    int errors = 0;
    int checks = 0;

    int       exp_phase;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    logic [3:0] exp_op;
    logic [3:0] exp_result;
    logic [3:0] exp_flags;
    logic       exp_valid;
    logic       exp_err;

    alu_operand_sequencer #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .sw          (sw),
        .op_sw       (op_sw),
        .btn_next    (btn_next),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_v       (alu_v),
        .alu_c       (alu_c),
        .alu_n       (alu_n),
        .alu_z       (alu_z),
        .result_q    (result_q),
        .flags_q     (flags_q),
        .phase       (phase),
        .valid       (valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {v,c,n,z,result}; subtract sets C as "no borrow".
    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] op);
        logic [4:0] wide;
        logic [3:0] r;
        logic       v;
        logic       c;
        v = 1'b0;
        c = 1'b0;
        r = 4'd0;
        case (op)
            4'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                r = wide[3:0];
                c = wide[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            4'd1: begin
                wide = {1'b0, a} + {1'b0, ~b} + 5'd1;
                r = wide[3:0];
                c = wide[4];
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a >> b;
            4'd6: r = a << b;
            4'd7: r = (b == 4'd0) ? 4'd0 : a % b;
            4'd8: r = a;
            4'd9: r = (b == 4'd0) ? 4'd0 : a / b;
            default: r = 4'd0;
        endcase
        return {v, c, r[3], (r == 4'd0), r};
    endfunction

    // The ALU sitting downstream of the sequencer.
    always_comb begin
        {alu_v, alu_c, alu_n, alu_z, alu_result} = alu_model(alu_a, alu_b, alu_control);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic check_all(input string where);
        checkOutput({where, ".phase"},  32'(phase),       32'(exp_phase));
        checkOutput({where, ".alu_a"},  32'(alu_a),       32'(exp_a));
        checkOutput({where, ".alu_b"},  32'(alu_b),       32'(exp_b));
        checkOutput({where, ".alu_op"}, 32'(alu_control), 32'(exp_op));
        checkOutput({where, ".result"}, 32'(result_q),    32'(exp_result));
        checkOutput({where, ".flags"},  32'(flags_q),     32'(exp_flags));
        checkOutput({where, ".valid"},  32'(valid),       32'(exp_valid));
        checkOutput({where, ".err"},    32'(err),         32'(exp_err));
    endtask

    // One button press held for 'hold' cycles; inputs change on negedges.
    task automatic applyStimulus(input int hold);
        logic [7:0] alu_out;
        btn_next = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("phase_before_step", 32'(phase), 32'(exp_phase));
        @(negedge clk);
        case (exp_phase)
            0: begin exp_a = sw; exp_valid = 1'b0; exp_err = 1'b0; exp_phase = 1; end
            1: begin exp_b = sw; exp_phase = 2; end
            2: begin exp_op = op_sw; exp_phase = 3; end
            4: begin exp_valid = 1'b0; exp_err = 1'b0; exp_phase = 0; end
            default: exp_phase = exp_phase;
        endcase
        check_all("step");
        sw    = 4'($urandom);
        op_sw = 4'($urandom);
        if (exp_phase == 3) begin
            @(negedge clk);
            exp_phase = 4;
            exp_valid = 1'b1;
            if (exp_op > 4'd9 || ((exp_op == 4'd7 || exp_op == 4'd9) && exp_b == 4'd0)) begin
                exp_result = 4'd0;
                exp_flags  = 4'd0;
                exp_err    = 1'b1;
            end else begin
                alu_out    = alu_model(exp_a, exp_b, exp_op);
                exp_result = alu_out[3:0];
                exp_flags  = alu_out[7:4];
                exp_err    = 1'b0;
            end
            check_all("capture");
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            sw    = 4'($urandom);
            op_sw = 4'($urandom);
        end
        btn_next = 1'b0;
        repeat (3) @(negedge clk);
        check_all("released");
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        if (exp_phase == 4) applyStimulus(1);
        sw = a;
        applyStimulus(1);
        sw = b;
        applyStimulus(1);
        op_sw = op;
        applyStimulus(2);
    endtask

    task automatic model_reset();
        exp_phase  = 0;
        exp_a      = 4'd0;
        exp_b      = 4'd0;
        exp_op     = 4'd0;
        exp_result = 4'd0;
        exp_flags  = 4'd0;
        exp_valid  = 1'b0;
        exp_err    = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        btn_next = 1'b0;
        sw       = 4'd0;
        op_sw    = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_all("reset");

        // Button hold in LOAD_A: only one step for a long press.
        sw = 4'h6;
        applyStimulus(20);

        // Finish that operation then run directed cases.
        sw = 4'h3;
        applyStimulus(1);
        op_sw = 4'd8;
        applyStimulus(1);

        run_op(4'h9, 4'h8, 4'd0);
        checkOutput("add_flags", 32'(flags_q), 32'b1100);
        run_op(4'h5, 4'h5, 4'd1);
        checkOutput("sub_zero", 32'(result_q), 32'h0);
        run_op(4'h7, 4'h0, 4'd9);
        checkOutput("div0_err", 32'(err), 32'h1);
        run_op(4'h7, 4'h0, 4'd7);
        checkOutput("mod0_err", 32'(err), 32'h1);
        run_op(4'h7, 4'h2, 4'd9);
        run_op(4'h4, 4'h3, 4'hC);
        applyStimulus(1);
        checkOutput("show_exit_phase", 32'(phase), 32'h0);

        // Randomized operations, biased towards B == 0 sometimes.
        for (int k = 0; k < 25; k++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic [3:0] rop;
            ra  = 4'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            rop = 4'($urandom_range(0, 15));
            run_op(ra, rb, rop);
        end

        // Reset during EXEC with the button still held.
        if (exp_phase == 4) applyStimulus(1);
        sw = 4'hA;
        applyStimulus(1);
        sw = 4'h3;
        applyStimulus(1);
        op_sw    = 4'd3;
        btn_next = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("exec_before_reset", 32'(phase), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        btn_next = 1'b0;
        model_reset();
        check_all("reset_in_exec");
        repeat (4) @(negedge clk);
        check_all("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
